cnu_sched: RTL and testbench

Row scheduler for the check-node unit pipeline of the LDPC decoder. It sequences check-node rows through the CNU for up to a programmable number of iterations. It generates message-memory read addresses, the CNU enable, and write-back addresses aligned to the CNU pipeline latency. It stops early when the parity checker reports convergence.

---
 rtl/cnu_sched_pkg.sv | 17 +
 rtl/cnu_sched_tag_pipe.sv | 50 +++++
 rtl/cnu_sched.sv | 141 ++++++++++++++
 tb/tb_cnu_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_sched_pkg.sv
// Shared decoder scheduling definitions: scheduler state encoding and the
// default code geometry used by both the CNU and VNU row schedulers.
package cnu_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_CHECK = 2'd3
   } sched_state_t;

   localparam int ROWS_DEF    = 64;
   localparam int ROW_W_DEF   = 6;
   localparam int ITER_W_DEF  = 5;
   localparam int CNU_LAT_DEF = 2;

endpackage

// File: rtl/cnu_sched_tag_pipe.sv
// CNU tag pipeline: a LAT-deep {valid, addr} shift register that follows each
// row through the CNU so its write-back address emerges with its result.
module cnu_tag_pipe #(
   parameter int LAT = 2,
   parameter int AW  = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          tail_valid,
   output logic [AW-1:0] tail_addr,
   output logic          body_valid
);

   logic [LAT-1:0] valid_q;
   logic [AW-1:0]  addr_q [LAT];

   // Shift all stages together whenever the pipeline is allowed to advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         // NOTE: the address stages are reset too (not just the valids) because
         // the tail address is a visible output whose reset value is defined.
         for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
      end else if (adv) begin
         valid_q[0] <= in_valid;
         addr_q[0]  <= in_addr;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign tail_valid = valid_q[LAT-1];
   assign tail_addr  = addr_q[LAT-1];

   // Rows still queued behind the tail; when none are left, the current tail
   // write is the last one and the pipeline is empty after the next advance.
   generate
      if (LAT > 1) begin : g_body
         assign body_valid = |valid_q[LAT-2:0];
      end else begin : g_nobody
         assign body_valid = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/cnu_sched.sv
// CNU row scheduler: issues message-memory reads row by row, tracks each row
// through the CNU latency for write-back, and repeats iterations until the
// parity checker reports convergence or the iteration limit is reached.
module cnu_sched
   import cnu_sched_pkg::*;
#(
   parameter int ROWS    = ROWS_DEF,
   parameter int ROW_W   = ROW_W_DEF,
   parameter int ITER_W  = ITER_W_DEF,
   parameter int CNU_LAT = CNU_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ITER_W-1:0] max_iter,
   input  logic              stall,
   input  logic              parity_ok,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              rd_en,
   output logic [ROW_W-1:0]  rd_addr,
   output logic              cnu_en,
   output logic              wr_en,
   output logic [ROW_W-1:0]  wr_addr
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   sched_state_t      state, state_nxt;
   logic [ROW_W-1:0]  row;
   logic [ITER_W-1:0] max_q;
   logic [ITER_W-1:0] iter_next;
   logic              load, row_inc, row_clr, iter_inc, finish;
   logic              tail_valid, body_valid;
   logic [ROW_W-1:0]  tail_addr;

   assign iter_next = iter_cnt + 1'b1;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path through
      // the case statement leaves a signal unassigned and infers a latch.
      state_nxt = state;
      load      = 1'b0;
      row_inc   = 1'b0;
      row_clr   = 1'b0;
      iter_inc  = 1'b0;
      finish    = 1'b0;
      rd_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               rd_en = 1'b1;
               // The row counter parks on the last row; it restarts only from CHECK.
               if (row == LAST_ROW) state_nxt = ST_DRAIN;
               else                 row_inc   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!stall && !body_valid) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            // Stall is deliberately ignored here: nothing is in flight.
            iter_inc = 1'b1;
            if (parity_ok || (iter_next == max_q)) begin
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               row_clr   = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Row counter: cleared at the start of every iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  row <= '0;
      else if (load || row_clr) row <= '0;
      else if (row_inc)         row <= row + 1'b1;
   end

   // Iteration bookkeeping and the completion flags reported with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q     <= '0;
         iter_cnt  <= '0;
         converged <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            // A limit of zero still runs one full iteration.
            max_q     <= (max_iter == '0) ? ITER_W'(1) : max_iter;
            iter_cnt  <= '0;
            converged <= 1'b0;
         end else if (iter_inc) begin
            iter_cnt <= iter_next;
         end
         if (finish) converged <= parity_ok;
      end
   end

   cnu_tag_pipe #(
      .LAT (CNU_LAT),
      .AW  (ROW_W)
   ) u_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .adv        (~stall),
      .in_valid   (rd_en),
      .in_addr    (rd_addr),
      .tail_valid (tail_valid),
      .tail_addr  (tail_addr),
      .body_valid (body_valid)
   );

   assign busy    = (state != ST_IDLE);
   assign cnu_en  = busy & ~stall;
   assign rd_addr = row;
   assign wr_en   = tail_valid & ~stall;
   assign wr_addr = tail_addr;

endmodule

// File: tb/tb_cnu_sched.sv
// Directed bench for cnu_sched with ROWS=4, CNU_LAT=2: a cycle table for the
// first iteration, then hand-written sequences for iteration count, early
// convergence, stalls, max_iter=0, mid-decode reset and start while busy.
module tb_cnu_sched;

   localparam int ROWS   = 4;
   localparam int ROW_W  = 2;
   localparam int ITER_W = 5;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ITER_W-1:0] max_iter;
   logic              stall;
   logic              parity_ok;
   logic              busy, done, converged, rd_en, cnu_en, wr_en;
   logic [ITER_W-1:0] iter_cnt;
   logic [ROW_W-1:0]  rd_addr, wr_addr;

   cnu_sched #(
      .ROWS    (ROWS),
      .ROW_W   (ROW_W),
      .ITER_W  (ITER_W),
      .CNU_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .max_iter  (max_iter),
      .stall     (stall),
      .parity_ok (parity_ok),
      .busy      (busy),
      .done      (done),
      .converged (converged),
      .iter_cnt  (iter_cnt),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .cnu_en    (cnu_en),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit start;
      bit rd_en;
      int rd_addr;
      bit wr_en;
      int wr_addr;
      bit busy;
      int iter;
   } vec_t;

   typedef struct {
      int addr;
      int cyc;
      int stall_mark;
   } rd_rec_t;

   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc;
   int      n_rd, n_wr, stall_total, exp_row;
   rd_rec_t rd_q[$];
   vec_t    tv[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_sb();
      rd_q.delete();
      n_rd        = 0;
      n_wr        = 0;
      stall_total = 0;
      exp_row     = 0;
   endtask

   // Let combinational outputs settle, then log reads/writes into the scoreboard.
   task automatic settle();
      rd_rec_t r;
      #2;
      if (stall) begin
         stall_total++;
         check("cnu_en_in_stall", cnu_en, 0);
         check("rd_en_in_stall", rd_en, 0);
         check("wr_en_in_stall", wr_en, 0);
      end
      if (rd_en) begin
         check("rd_addr_seq", rd_addr, exp_row);
         r.addr       = exp_row;
         r.cyc        = cyc;
         r.stall_mark = stall_total;
         rd_q.push_back(r);
         exp_row = (exp_row + 1) % ROWS;
         n_rd++;
      end
      if (wr_en) begin
         n_wr++;
         if (rd_q.size() == 0) begin
            check("wr_without_read", rd_q.size(), 1);
         end else begin
            r = rd_q.pop_front();
            check("wr_addr_order", wr_addr, r.addr);
            check("wr_latency", cyc - r.cyc, LAT + stall_total - r.stall_mark);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_decode(input logic [ITER_W-1:0] mi);
      cyc = 0;
      clear_sb();
      max_iter = mi;
      start    = 1'b1;
      stall    = 1'b0;
      settle();
      check("idle_before_start", busy, 0);
      advance();
      start    = 1'b0;
      max_iter = ~mi;   // must have been latched on start
   endtask

   task automatic run_to_done(input int st_lo, input int st_hi, input int start_at,
                              input int budget, output int done_cyc);
      done_cyc = -1;
      while (cyc < budget) begin
         stall = (cyc >= st_lo) && (cyc <= st_hi);
         start = (cyc == start_at);
         settle();
         if (done) begin
            done_cyc = cyc;
            break;
         end
         advance();
      end
      stall = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_checks(input int done_cyc, input int exp_cyc, input int exp_iter,
                                input bit exp_conv, input int exp_n);
      check("done_cycle", done_cyc, exp_cyc);
      check("iter_cnt_at_done", iter_cnt, exp_iter);
      check("converged_at_done", converged, exp_conv);
      check("busy_at_done", busy, 0);
      check("reads_total", n_rd, exp_n);
      check("writes_total", n_wr, exp_n);
      check("reads_outstanding", rd_q.size(), 0);
      advance();
      settle();
      check("done_one_cycle", done, 0);
      check("iter_cnt_held", iter_cnt, exp_iter);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int dc;

      // Cycle table for the first iteration plus first row of the second (ROWS=4).
      //          start rd  rda wr  wra busy iter
      tv[0] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0};
      tv[1] = '{1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 0};
      tv[2] = '{1'b0, 1'b1, 1, 1'b0, 0, 1'b1, 0};
      tv[3] = '{1'b0, 1'b1, 2, 1'b1, 0, 1'b1, 0};
      tv[4] = '{1'b0, 1'b1, 3, 1'b1, 1, 1'b1, 0};
      tv[5] = '{1'b0, 1'b0, 0, 1'b1, 2, 1'b1, 0};
      tv[6] = '{1'b0, 1'b0, 0, 1'b1, 3, 1'b1, 0};
      tv[7] = '{1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0};
      tv[8] = '{1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1};

      rst = 1'b1; start = 1'b0; stall = 1'b0; parity_ok = 1'b0; max_iter = '0;
      cyc = 0;
      clear_sb();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_converged", converged, 0);
      check("rst_iter_cnt", iter_cnt, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_cnu_en", cnu_en, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      rst = 1'b0;
      advance();

      // Three full iterations, no stall, parity never ok.
      cyc = 0;
      clear_sb();
      max_iter = 5'd3;
      for (int i = 0; i < 9; i++) begin
         start = tv[i].start;
         settle();
         check("tv_rd_en", rd_en, tv[i].rd_en);
         if (tv[i].rd_en) check("tv_rd_addr", rd_addr, tv[i].rd_addr);
         check("tv_wr_en", wr_en, tv[i].wr_en);
         if (tv[i].wr_en) check("tv_wr_addr", wr_addr, tv[i].wr_addr);
         check("tv_busy", busy, tv[i].busy);
         check("tv_cnu_en", cnu_en, tv[i].busy);
         check("tv_done", done, 0);
         check("tv_iter_cnt", iter_cnt, tv[i].iter);
         advance();
         start    = 1'b0;
         max_iter = 5'd9;
      end
      run_to_done(-1, -1, -1, 200, dc);
      finish_checks(dc, 22, 3, 1'b0, 12);

      // Convergence at the first CHECK.
      parity_ok = 1'b1;
      begin_decode(5'd3);
      run_to_done(-1, -1, -1, 200, dc);
      finish_checks(dc, 8, 1, 1'b1, 4);
      parity_ok = 1'b0;

      // Two stalled cycles mid-RUN shift everything by two.
      begin_decode(5'd1);
      run_to_done(2, 3, -1, 200, dc);
      finish_checks(dc, 10, 1, 1'b0, 4);

      // max_iter=0 runs one iteration; a stall during CHECK changes nothing.
      begin_decode(5'd0);
      run_to_done(7, 7, -1, 200, dc);
      finish_checks(dc, 8, 1, 1'b0, 4);

      // Reset during DRAIN, then a normal decode.
      begin_decode(5'd3);
      while (cyc < 5) begin
         settle();
         advance();
      end
      settle();
      check("drain_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_rd_addr", rd_addr, 0);
      check("mid_rst_cnu_en", cnu_en, 0);
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_wr_addr", wr_addr, 0);
      check("mid_rst_iter_cnt", iter_cnt, 0);
      check("mid_rst_done", done, 0);
      advance();
      rst = 1'b0;
      clear_sb();
      for (int i = 0; i < 8; i++) begin
         settle();
         check("post_rst_no_done", done, 0);
         check("post_rst_idle", busy, 0);
         advance();
      end
      begin_decode(5'd1);
      run_to_done(-1, -1, -1, 200, dc);
      finish_checks(dc, 8, 1, 1'b0, 4);

      // start pulsed during CHECK while busy is ignored.
      begin_decode(5'd2);
      run_to_done(-1, -1, 7, 200, dc);
      finish_checks(dc, 15, 2, 1'b0, 8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
